hex_display_bank: RTL and testbench



---
 rtl/hex_display_bank_if.sv | 34 +++
 rtl/hex_display_bank.sv | 165 ++++++++++++++++
 tb/tb_hex_display_bank.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_display_bank_if.sv
// Bus bundle between score/game logic and the hex_display_bank driver.
// BLINK_MASK exists only when BLINK_EN is defined.
interface hex_display_bank_if #(
  parameter int DIGITS = 4,
  parameter int VAL_W  = 16
);
  logic                  LOAD;
  logic [VAL_W-1:0]      VALUE;
  logic                  DEC_MODE;
  logic                  LZ_BLANK;
`ifdef BLINK_EN
  logic [DIGITS-1:0]     BLINK_MASK;
`endif
  logic                  BUSY;
  logic                  DONE;
  logic                  OVERFLOW;
  logic [7*DIGITS-1:0]   SEG;

  modport master (
    output LOAD, VALUE, DEC_MODE, LZ_BLANK,
`ifdef BLINK_EN
    output BLINK_MASK,
`endif
    input  BUSY, DONE, OVERFLOW, SEG
  );

  modport slave (
    input  LOAD, VALUE, DEC_MODE, LZ_BLANK,
`ifdef BLINK_EN
    input  BLINK_MASK,
`endif
    output BUSY, DONE, OVERFLOW, SEG
  );
endinterface

// File: rtl/hex_display_bank.sv
// Multi-digit seven-segment driver: hex or decimal (double-dabble) display with
// leading-zero blanking and overflow dashes. Optional digit blinking via BLINK_EN.
module hex_display_bank #(
  parameter int DIGITS = 4,
  parameter int VAL_W  = 16
`ifdef BLINK_EN
  , parameter int BLINK_DIV = 25000000
`endif
) (
  input  logic              CLK,
  input  logic              RESET,
  hex_display_bank_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int EW = (VAL_W > BW) ? VAL_W : BW;

  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;
  state_t r_state, w_next;

  logic [BW-1:0]     r_disp, r_bcd, w_bcd_adj, w_bcd_next;
  logic [VAL_W-1:0]  r_sh;
  logic [5:0]        r_cnt;
  logic              r_valid, r_ovf, r_sticky, r_dec, r_done;
  logic              w_accept, w_step_ovf;
  logic [EW-1:0]     w_ext;
  logic [DIGITS-1:0] w_lead, w_blank_mask;
  logic              w_lz_run;
  logic [7*DIGITS-1:0] w_seg;

  // Refusing LOAD while DONE is high keeps DONE from pulsing twice in a row.
  assign w_accept = (r_state == IDLE) && bus.LOAD && !r_done;
  assign w_ext    = EW'(bus.VALUE);

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && bus.DEC_MODE) w_next = CONV;
      CONV:    if (r_cnt == '0) w_next = UPDATE;
      UPDATE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    // A top nibble >= 5 becomes >= 8 after correction, so a 1 leaves the register.
    w_step_ovf = (r_bcd[BW-1 -: 4] >= 4'd5);
    w_bcd_next = {w_bcd_adj[BW-2:0], r_sh[VAL_W-1]};
  end

  // The final shift writes the display directly so DONE coincides with UPDATE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_disp   <= '0;
      r_bcd    <= '0;
      r_sh     <= '0;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_sticky <= 1'b0;
      r_dec    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept && !bus.DEC_MODE) begin
        r_disp  <= w_ext[BW-1:0];
        r_ovf   <= ((w_ext >> BW) != '0);
        r_dec   <= 1'b0;
        r_valid <= 1'b1;
        r_done  <= 1'b1;
      end else if (w_accept) begin
        r_sh     <= bus.VALUE;
        r_bcd    <= '0;
        r_sticky <= 1'b0;
        r_cnt    <= 6'(VAL_W - 1);
      end else if (r_state == CONV) begin
        r_sh     <= r_sh << 1;
        r_bcd    <= w_bcd_next;
        r_sticky <= r_sticky | w_step_ovf;
        r_cnt    <= r_cnt - 6'd1;
        if (r_cnt == '0) begin
          r_disp  <= w_bcd_next;
          r_ovf   <= r_sticky | w_step_ovf;
          r_dec   <= 1'b1;
          r_valid <= 1'b1;
          r_done  <= 1'b1;
        end
      end
    end
  end

`ifdef BLINK_EN
  logic [31:0] r_bcnt;
  logic        r_phase;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (r_bcnt == 32'(BLINK_DIV - 1)) begin
      r_bcnt  <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_bcnt <= r_bcnt + 32'd1;
    end
  end

  assign w_blank_mask = r_phase ? bus.BLINK_MASK : '0;
`else
  assign w_blank_mask = '0;
`endif

  function automatic logic [6:0] f_seg(input logic [3:0] n);
    case (n)
      4'h0: f_seg = 7'b1000000;
      4'h1: f_seg = 7'b1111001;
      4'h2: f_seg = 7'b0100100;
      4'h3: f_seg = 7'b0110000;
      4'h4: f_seg = 7'b0011001;
      4'h5: f_seg = 7'b0010010;
      4'h6: f_seg = 7'b0000010;
      4'h7: f_seg = 7'b1111000;
      4'h8: f_seg = 7'b0000000;
      4'h9: f_seg = 7'b0010000;
      4'hA: f_seg = 7'b0001000;
      4'hB: f_seg = 7'b0000011;
      4'hC: f_seg = 7'b1000110;
      4'hD: f_seg = 7'b0100001;
      4'hE: f_seg = 7'b0000110;
      default: f_seg = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    w_lead   = '0;
    w_lz_run = 1'b1;
    w_seg    = '1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      w_lz_run = w_lz_run && (r_disp[4*(DIGITS-1-k) +: 4] == 4'd0);
      w_lead[DIGITS-1-k] = w_lz_run;
    end
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!r_valid || w_blank_mask[i])
        w_seg[7*i +: 7] = 7'b1111111;
      else if (r_dec && r_ovf)
        w_seg[7*i +: 7] = 7'b0111111;
      else if (bus.LZ_BLANK && w_lead[i] && (i != 0))
        w_seg[7*i +: 7] = 7'b1111111;
      else
        w_seg[7*i +: 7] = f_seg(r_disp[4*i +: 4]);
    end
  end

  assign bus.SEG      = w_seg;
  assign bus.BUSY     = (r_state == CONV);
  assign bus.DONE     = r_done;
  assign bus.OVERFLOW = r_ovf;
endmodule

// File: tb/tb_hex_display_bank.sv
// Scoreboard bench for hex_display_bank (DIGITS=4, VAL_W=16); define BLINK_EN to
// also exercise digit blinking with BLINK_DIV=4.
module tb_hex_display_bank;
  localparam int DIGITS = 4;
  localparam int VAL_W  = 16;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  hex_display_bank_if #(.DIGITS(DIGITS), .VAL_W(VAL_W)) bus ();

  hex_display_bank #(
    .DIGITS(DIGITS),
    .VAL_W(VAL_W)
`ifdef BLINK_EN
    , .BLINK_DIV(4)
`endif
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  typedef struct {
    logic [27:0] seg;
    logic        ovf;
    int          lat;
    int          busy;
    int          load_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int asserts  = 0;
  int fails    = 0;
  int cyc      = 0;
  int busy_cyc = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge CLK);
    cyc++;
    if (bus.BUSY) busy_cyc++;
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic model_ovf(input logic [15:0] v, input logic dec);
    return dec && (int'(v) >= 10000);
  endfunction

  function automatic logic [27:0] model_seg(input logic [15:0] v, input logic dec, input logic lz);
    logic [3:0]  d [4];
    logic [27:0] s;
    int p = 1;
    int msd = 0;
    for (int i = 0; i < 4; i++) begin
      d[i] = dec ? 4'((int'(v) / p) % 10) : v[4*i +: 4];
      p = p * 10;
    end
    if (model_ovf(v, dec)) return {4{7'b0111111}};
    for (int i = 0; i < 4; i++) if (d[i] != 4'd0) msd = i;
    for (int i = 0; i < 4; i++)
      s[7*i +: 7] = (lz && i > msd) ? 7'b1111111 : seg_of(d[i]);
    return s;
  endfunction

  task automatic send(input logic [15:0] v, input logic dec, input string name);
    exp_t e;
    tick();
    bus.LOAD     = 1'b1;
    bus.VALUE    = v;
    bus.DEC_MODE = dec;
    e.seg      = model_seg(v, dec, bus.LZ_BLANK);
    e.ovf      = model_ovf(v, dec);
    e.lat      = dec ? VAL_W + 1 : 1;
    e.busy     = dec ? VAL_W : 0;
    e.load_cyc = cyc;
    e.name     = name;
    sb.push_back(e);
    busy_cyc = 0;
  endtask

  task automatic collect();
    exp_t e;
    int n = 0;
    if (sb.size() == 0) begin
      asserts++; fails++;
      $display("FAIL scoreboard: queue empty when collecting");
      return;
    end
    e = sb.pop_front();
    do begin
      tick();
      bus.LOAD = 1'b0;
      n++;
    end while (!bus.DONE && n < 40);
    asserts++;
    if (bus.DONE !== 1'b1) begin
      fails++; $display("FAIL %s done_timeout: DONE=%b after %0d cycles, required 1", e.name, bus.DONE, n);
    end
    asserts++;
    if (cyc - e.load_cyc !== e.lat) begin
      fails++; $display("FAIL %s latency: got %0d required %0d", e.name, cyc - e.load_cyc, e.lat);
    end
    asserts++;
    if (busy_cyc !== e.busy) begin
      fails++; $display("FAIL %s busy_cycles: got %0d required %0d", e.name, busy_cyc, e.busy);
    end
    asserts++;
    if (bus.SEG !== e.seg) begin
      fails++; $display("FAIL %s seg: got %b required %b", e.name, bus.SEG, e.seg);
    end
    asserts++;
    if (bus.OVERFLOW !== e.ovf) begin
      fails++; $display("FAIL %s overflow: got %b required %b", e.name, bus.OVERFLOW, e.ovf);
    end
    asserts++;
    if (bus.BUSY !== 1'b0) begin
      fails++; $display("FAIL %s busy_at_done: got %b required 0", e.name, bus.BUSY);
    end
    tick();
    asserts++;
    if (bus.DONE !== 1'b0) begin
      fails++; $display("FAIL %s done_pulse: DONE=%b on second cycle, required 0", e.name, bus.DONE);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
    tick();
    asserts++;
    if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", bus.BUSY); end
    asserts++;
    if (bus.DONE !== 1'b0) begin fails++; $display("FAIL reset_done: got %b required 0", bus.DONE); end
    asserts++;
    if (bus.OVERFLOW !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b required 0", bus.OVERFLOW); end
    asserts++;
    if (bus.SEG !== {28{1'b1}}) begin fails++; $display("FAIL reset_seg: got %b required all ones", bus.SEG); end
  endtask

  task automatic test_hex();
    bus.LZ_BLANK = 1'b0;
    send(16'h1A3F, 1'b0, "hex_1A3F");
    collect();
    asserts++;
    if (bus.SEG !== {7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110}) begin
      fails++; $display("FAIL hex_1A3F_literal: got %b required 1111001 0001000 0110000 0001110", bus.SEG);
    end
    send(16'hBCDE, 1'b0, "hex_BCDE"); collect();
    send(16'h5678, 1'b0, "hex_5678"); collect();
    send(16'h2490, 1'b0, "hex_2490"); collect();
  endtask

  task automatic test_decimal();
    bus.LZ_BLANK = 1'b0;
    send(16'd1234, 1'b1, "dec_1234"); collect();
    send(16'd9876, 1'b1, "dec_9876"); collect();
    send(16'd9999, 1'b1, "dec_9999"); collect();
    send(16'd0,    1'b1, "dec_0");    collect();
  endtask

  task automatic test_overflow();
    send(16'd12345, 1'b1, "dec_12345");    collect();
    send(16'h0001,  1'b0, "hex_after_ovf"); collect();
    send(16'd10000, 1'b1, "dec_10000");    collect();
    send(16'hFFFF,  1'b1, "dec_65535");    collect();
    send(16'd5000,  1'b1, "dec_5000");     collect();
  endtask

  task automatic test_lz_blank();
    bus.LZ_BLANK = 1'b1;
    send(16'h0007,  1'b0, "lz_hex_7");     collect();
    send(16'h0000,  1'b0, "lz_hex_0");     collect();
    send(16'd42,    1'b1, "lz_dec_42");    collect();
    send(16'd12345, 1'b1, "lz_dec_ovf");   collect();
    send(16'h0100,  1'b0, "lz_hex_0100");  collect();
    bus.LZ_BLANK = 1'b0;
    tick();
    asserts++;
    if (bus.SEG !== model_seg(16'h0100, 1'b0, 1'b0)) begin
      fails++; $display("FAIL lz_live_off: got %b required %b", bus.SEG, model_seg(16'h0100, 1'b0, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    send(16'hC0DE, 1'b0, "b2b_hex1");  collect();
    send(16'd8001, 1'b1, "b2b_dec");   collect();
    send(16'h00F0, 1'b0, "b2b_hex2");  collect();
  endtask

  task automatic test_busy_ignore();
    int dones = 0;
    send(16'd9999, 1'b1, "ignore_9999");
    repeat (4) begin
      tick();
      bus.LOAD = 1'b0;
    end
    bus.LOAD     = 1'b1;
    bus.VALUE    = 16'd42;
    bus.DEC_MODE = 1'b1;
    collect();
    repeat (25) begin
      tick();
      if (bus.DONE) dones++;
    end
    asserts++;
    if (dones !== 0) begin fails++; $display("FAIL ignore_no_queue: got %0d extra DONE pulses required 0", dones); end
  endtask

  task automatic test_reset_midconv();
    int dones = 0;
    tick();
    bus.LOAD     = 1'b1;
    bus.VALUE    = 16'd9999;
    bus.DEC_MODE = 1'b1;
    repeat (7) begin
      tick();
      bus.LOAD = 1'b0;
    end
    asserts++;
    if (bus.BUSY !== 1'b1) begin fails++; $display("FAIL midconv_busy: got %b required 1", bus.BUSY); end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    asserts++;
    if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL midconv_reset_busy: got %b required 0", bus.BUSY); end
    asserts++;
    if (bus.SEG !== {28{1'b1}}) begin fails++; $display("FAIL midconv_reset_seg: got %b required all ones", bus.SEG); end
    repeat (25) begin
      tick();
      if (bus.DONE) dones++;
    end
    asserts++;
    if (dones !== 0) begin fails++; $display("FAIL midconv_no_done: got %0d DONE pulses required 0", dones); end
    asserts++;
    if (bus.SEG !== {28{1'b1}}) begin fails++; $display("FAIL midconv_blank_hold: got %b required all ones", bus.SEG); end
  endtask

`ifdef BLINK_EN
  task automatic test_blink();
    logic [27:0] shown;
    logic        prev_blank;
    int          last_tr = -1;
    int          trans = 0;
    bus.LZ_BLANK   = 1'b0;
    bus.BLINK_MASK = 4'b0001;
    shown = model_seg(16'h1234, 1'b0, 1'b0);
    send(16'h1234, 1'b0, "blink_load");
    tick();
    bus.LOAD = 1'b0;
    void'(sb.pop_front());
    prev_blank = (bus.SEG[6:0] == 7'b1111111);
    for (int s = 0; s < 32; s++) begin
      tick();
      asserts++;
      if (bus.SEG[27:7] !== shown[27:7]) begin
        fails++; $display("FAIL blink_upper: got %b required %b", bus.SEG[27:7], shown[27:7]);
      end
      asserts++;
      if (bus.SEG[6:0] !== shown[6:0] && bus.SEG[6:0] !== 7'b1111111) begin
        fails++; $display("FAIL blink_digit0: got %b required %b or 1111111", bus.SEG[6:0], shown[6:0]);
      end
      if ((bus.SEG[6:0] == 7'b1111111) != prev_blank) begin
        if (last_tr >= 0) begin
          asserts++;
          if (cyc - last_tr !== 4) begin
            fails++; $display("FAIL blink_period: got %0d cycles required 4", cyc - last_tr);
          end
        end
        last_tr = cyc;
        trans++;
        prev_blank = (bus.SEG[6:0] == 7'b1111111);
      end
    end
    asserts++;
    if (trans < 6) begin fails++; $display("FAIL blink_toggles: got %0d transitions required at least 6", trans); end
    bus.BLINK_MASK = 4'b0000;
  endtask
`endif

  initial begin
    RESET        = 1'b1;
    bus.LOAD     = 1'b0;
    bus.VALUE    = '0;
    bus.DEC_MODE = 1'b0;
    bus.LZ_BLANK = 1'b0;
`ifdef BLINK_EN
    bus.BLINK_MASK = '0;
`endif
    test_reset();
    test_hex();
    test_decimal();
    test_overflow();
    test_lz_blank();
    test_back_to_back();
    test_busy_ignore();
    test_reset_midconv();
`ifdef BLINK_EN
    test_blink();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
